// File: rtl/alu_req_sched_pkg.sv
// alu_req_sched_pkg
//   Shared encodings and default sizing for the ALU request scheduler:
//   FSM state encoding, ALU func codes and default parameter values.
package alu_req_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    localparam int NUM_REQ   = 2;
    localparam int DEF_WIDTH = 6;
    localparam int DEF_LAT   = 2;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/alu_req_sched_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin grant.
//   valid   : per-requester request valid
//   last    : id granted most recently (pointer register lives in the parent)
//   gnt_vld : some requester is valid
//   gnt_id  : granted requester; on a tie the one that was not granted last
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |valid;
        gnt_id  = valid[1];
        if (&valid) gnt_id = ~last;
    end

endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched
//   Round-robin sequencer that shares one combinational ALU between two
//   requesters. One operation in flight: accept, hold operands for lat
//   settle cycles, capture result/overflow, return it tagged with the id.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : per-requester handshake (bit i = requester i)
//   req_a/req_b/req_func     : packed operands, requester i at [i*width +: width]
//   alu_a/alu_b/alu_func     : registered operands to the shared ALU
//   alu_out/alu_ovf          : ALU result and overflow flag
//   rsp_valid/rsp_ready      : response handshake
//   rsp_id/rsp_result/rsp_err: captured response (held after handshake)
//   busy                     : FSM not idle
//   err_count                : saturating count of error responses
module alu_req_sched
    import alu_req_sched_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int lat   = DEF_LAT,
    parameter int cnt_w = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*width-1:0]   req_a,
    input  logic [2*width-1:0]   req_b,
    input  logic [3:0]           req_func,
    output logic [width-1:0]     alu_a,
    output logic [width-1:0]     alu_b,
    output logic [1:0]           alu_func,
    input  logic [2*width-1:0]   alu_out,
    input  logic                 alu_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*width-1:0]   rsp_result,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [cnt_w-1:0]     err_count
);

    localparam int              CW       = (lat > 1) ? $clog2(lat) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(lat - 1);

    // Per-lane views of the packed request buses (same bit layout).
    logic [NUM_REQ-1:0][width-1:0] lane_a, lane_b;
    logic [NUM_REQ-1:0][1:0]       lane_f;

    assign lane_a = req_a;
    assign lane_b = req_b;
    assign lane_f = req_func;

    state_t             state_q, state_d;
    logic               last_q;
    logic [CW-1:0]      cnt_q;
    logic [width-1:0]   op_a_q, op_b_q;
    logic [1:0]         op_f_q;
    logic               op_id_q;
    logic               gnt_vld, gnt_id;
    logic               accept;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .last    (last_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) req_ready[gnt_id] = 1'b1;
                accept = |(req_valid & req_ready);
                if (accept) state_d = EXEC;
            end
            EXEC:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;   // requester 0 wins the first tie
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_f_q     <= '0;
            op_id_q    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q  <= lane_a[gnt_id];
                        op_b_q  <= lane_b[gnt_id];
                        op_f_q  <= lane_f[gnt_id];
                        op_id_q <= gnt_id;
                        last_q  <= gnt_id;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        // Result is forced to zero on overflow so the display
                        // never shows a meaningless partial value.
                        rsp_valid  <= 1'b1;
                        rsp_result <= alu_ovf ? '0 : alu_out;
                        rsp_err    <= alu_ovf;
                        rsp_id     <= op_id_q;
                        if (alu_ovf && (err_count != '1))
                            err_count <= err_count + cnt_w'(1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP:    if (rsp_ready) rsp_valid <= 1'b0;
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

    assign alu_a    = op_a_q;
    assign alu_b    = op_b_q;
    assign alu_func = op_f_q;
    assign busy     = (state_q != IDLE);

endmodule
